fetch_scheduler: RTL and testbench

- Multi-thread fetch scheduler for the OOO core front end.
- Owns one PC per hardware thread and arbitrates round-robin among eligible threads for the single instruction-memory port.
- Sequences each fetch through a request/response handshake, applies backend redirects and flushes per thread, and delivers fetched instructions tagged with thread ID to the instruction queue.

---
 rtl/rv32i_types.sv | 13 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/fetch_scheduler.sv | 137 +++++++++++++
 tb/tb_fetch_scheduler.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared front-end types: fetch scheduler FSM states and per-thread reset PC layout.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } fetch_sched_state_t;

  localparam logic [31:0] RESET_PC     = 32'h6000_0000;
  localparam logic [31:0] RESET_STRIDE = 32'h0000_1000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requesting thread at or after rr_ptr, circularly.
module rr_arbiter #(
  parameter int unsigned NUM_THREADS = 2,
  localparam int unsigned TID_W = $clog2(NUM_THREADS)
) (
  input  logic [NUM_THREADS-1:0] req,
  input  logic [TID_W-1:0]       rr_ptr,
  output logic                   grant_valid,
  output logic [TID_W-1:0]       grant_tid
);

  logic [TID_W-1:0] idx;

  always_comb begin
    grant_valid = 1'b0;
    grant_tid   = '0;
    idx         = '0;
    // NUM_THREADS is a power of two, so TID_W-bit addition wraps around the ring
    for (int unsigned i = 0; i < NUM_THREADS; i++) begin
      idx = rr_ptr + TID_W'(i);
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_tid   = idx;
      end
    end
  end

endmodule

// File: rtl/fetch_scheduler.sv
// Multi-thread fetch scheduler: per-thread PCs, round-robin grant of the single imem port,
// one outstanding request, delivers tagged instructions to the instruction queue.
module fetch_scheduler #(
  parameter int unsigned NUM_THREADS  = 2,
  parameter logic [31:0] RESET_PC     = rv32i_types::RESET_PC,
  parameter logic [31:0] RESET_STRIDE = rv32i_types::RESET_STRIDE,
  localparam int unsigned TID_W = $clog2(NUM_THREADS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_THREADS-1:0]    thread_en,
  input  logic [NUM_THREADS-1:0]    iq_full,
  input  logic [NUM_THREADS-1:0]    redir_valid,
  input  logic [NUM_THREADS*32-1:0] redir_pc,
  input  logic [NUM_THREADS-1:0]    flush_valid,
  input  logic [NUM_THREADS*32-1:0] flush_pc,
  output logic                      imem_req,
  output logic [31:0]               imem_addr,
  input  logic                      imem_ready,
  input  logic                      imem_resp,
  input  logic [31:0]               imem_rdata,
  output logic                      fetch_valid,
  output logic [31:0]               fetch_pc,
  output logic [31:0]               fetch_inst,
  output logic [TID_W-1:0]          fetch_tid,
  output logic [NUM_THREADS*32-1:0] thread_pc
);
  import rv32i_types::*;

  fetch_sched_state_t     state_q;
  logic [31:0]            pc_q [NUM_THREADS];
  logic [TID_W-1:0]       cur_tid_q;
  logic [TID_W-1:0]       rr_ptr_q;
  logic                   stale_q;

  logic [NUM_THREADS-1:0] hit;
  logic [NUM_THREADS-1:0] eligible;
  logic                   cur_hit;
  logic                   deliver;
  logic                   grant_valid;
  logic [TID_W-1:0]       grant_tid;

  assign hit      = flush_valid | redir_valid;
  assign eligible = thread_en & ~iq_full & ~hit;
  assign cur_hit  = hit[cur_tid_q];
  assign deliver  = (state_q == WAIT) && imem_resp && !stale_q && !cur_hit;

  rr_arbiter #(
    .NUM_THREADS(NUM_THREADS)
  ) u_rr_arbiter (
    .req        (eligible),
    .rr_ptr     (rr_ptr_q),
    .grant_valid(grant_valid),
    .grant_tid  (grant_tid)
  );

  // Flush beats redirect beats advance-on-delivery.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned t = 0; t < NUM_THREADS; t++) begin
        pc_q[t] <= RESET_PC + RESET_STRIDE * t;
      end
    end else begin
      for (int unsigned t = 0; t < NUM_THREADS; t++) begin
        if (flush_valid[t]) begin
          pc_q[t] <= flush_pc[32*t +: 32];
        end else if (redir_valid[t]) begin
          pc_q[t] <= redir_pc[32*t +: 32];
        end else if (deliver && cur_tid_q == TID_W'(t)) begin
          pc_q[t] <= pc_q[t] + 32'd4;
        end
      end
    end
  end

  always_comb begin
    thread_pc = '0;
    for (int unsigned t = 0; t < NUM_THREADS; t++) begin
      thread_pc[32*t +: 32] = pc_q[t];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cur_tid_q   <= '0;
      rr_ptr_q    <= '0;
      stale_q     <= 1'b0;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      fetch_valid <= 1'b0;
      fetch_pc    <= '0;
      fetch_inst  <= '0;
      fetch_tid   <= '0;
    end else begin
      fetch_valid <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grant_valid) begin
            cur_tid_q <= grant_tid;
            imem_req  <= 1'b1;
            imem_addr <= pc_q[grant_tid];
            state_q   <= REQ;
          end
        end
        REQ: begin
          // Accepted requests must complete; a hit at acceptance only poisons the response.
          if (imem_ready) begin
            imem_req <= 1'b0;
            stale_q  <= cur_hit;
            state_q  <= WAIT;
          end else if (cur_hit) begin
            imem_req <= 1'b0;
            state_q  <= IDLE;
          end
        end
        WAIT: begin
          if (imem_resp) begin
            if (deliver) begin
              fetch_valid <= 1'b1;
              fetch_pc    <= imem_addr;
              fetch_inst  <= imem_rdata;
              fetch_tid   <= cur_tid_q;
            end
            rr_ptr_q <= cur_tid_q + TID_W'(1);
            stale_q  <= 1'b0;
            state_q  <= IDLE;
          end else if (cur_hit) begin
            stale_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_scheduler.sv
// Directed plus randomized bench for fetch_scheduler against a transaction-level reference model.
module tb_fetch_scheduler;

  localparam int unsigned NT      = 2;
  localparam logic [31:0] RPC     = 32'h6000_0000;
  localparam logic [31:0] RSTRIDE = 32'h0000_1000;

  logic            clk = 1'b0;
  logic            rst;
  logic [NT-1:0]   thread_en, iq_full, redir_valid, flush_valid;
  logic [NT*32-1:0] redir_pc, flush_pc;
  logic            imem_req;
  logic [31:0]     imem_addr;
  logic            imem_ready, imem_resp;
  logic [31:0]     imem_rdata;
  logic            fetch_valid;
  logic [31:0]     fetch_pc, fetch_inst;
  logic [0:0]      fetch_tid;
  logic [NT*32-1:0] thread_pc;

  int tests = 0;
  int fails = 0;

  fetch_scheduler #(
    .NUM_THREADS (NT),
    .RESET_PC    (RPC),
    .RESET_STRIDE(RSTRIDE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .thread_en  (thread_en),
    .iq_full    (iq_full),
    .redir_valid(redir_valid),
    .redir_pc   (redir_pc),
    .flush_valid(flush_valid),
    .flush_pc   (flush_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_resp  (imem_resp),
    .imem_rdata (imem_rdata),
    .fetch_valid(fetch_valid),
    .fetch_pc   (fetch_pc),
    .fetch_inst (fetch_inst),
    .fetch_tid  (fetch_tid),
    .thread_pc  (thread_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model: phase 0 = no fetch in flight, 1 = request offered, 2 = awaiting response.
  int          m_phase, m_tid, m_rr;
  bit          m_stale;
  logic [31:0] m_pc [NT];
  logic        e_req, e_fv;
  logic [31:0] e_addr, e_fpc, e_finst;
  int          e_ftid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_phase = 0; m_tid = 0; m_rr = 0; m_stale = 0;
    for (int t = 0; t < NT; t++) m_pc[t] = RPC + RSTRIDE * t;
    e_req = 0; e_addr = 0; e_fv = 0; e_fpc = 0; e_finst = 0; e_ftid = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic m_step();
    bit h [NT];
    int dlv, t;
    dlv  = -1;
    e_fv = 0;
    for (int i = 0; i < NT; i++) h[i] = flush_valid[i] | redir_valid[i];
    case (m_phase)
      0: begin
        for (int i = 0; i < NT; i++) begin
          t = (m_rr + i) % NT;
          if (m_phase == 0 && thread_en[t] && !iq_full[t] && !h[t]) begin
            m_tid = t; m_phase = 1; e_req = 1; e_addr = m_pc[t];
          end
        end
      end
      1: begin
        if (imem_ready) begin
          e_req = 0; m_stale = h[m_tid]; m_phase = 2;
        end else if (h[m_tid]) begin
          e_req = 0; m_phase = 0;
        end
      end
      default: begin
        if (imem_resp) begin
          if (!m_stale && !h[m_tid]) begin
            e_fv = 1; e_fpc = e_addr; e_finst = imem_rdata; e_ftid = m_tid; dlv = m_tid;
          end
          m_rr = (m_tid + 1) % NT; m_stale = 0; m_phase = 0;
        end else if (h[m_tid]) begin
          m_stale = 1;
        end
      end
    endcase
    for (int i = 0; i < NT; i++) begin
      if (flush_valid[i]) m_pc[i] = flush_pc[32*i +: 32];
      else if (redir_valid[i]) m_pc[i] = redir_pc[32*i +: 32];
      else if (i == dlv) m_pc[i] = m_pc[i] + 32'd4;
    end
  endtask

  // Called just after a negedge with inputs set; returns at the following negedge.
  task automatic cycle();
    m_step();
    @(posedge clk);
    #1;
    chk("imem_req", 32'(imem_req), 32'(e_req));
    chk("imem_addr", imem_addr, e_addr);
    chk("fetch_valid", 32'(fetch_valid), 32'(e_fv));
    chk("fetch_pc", fetch_pc, e_fpc);
    chk("fetch_inst", fetch_inst, e_finst);
    chk("fetch_tid", 32'(fetch_tid), 32'(e_ftid));
    for (int t = 0; t < NT; t++) chk($sformatf("thread_pc%0d", t), thread_pc[32*t +: 32], m_pc[t]);
    @(negedge clk);
  endtask

  task automatic quiet();
    thread_en = '0; iq_full = '0; redir_valid = '0; flush_valid = '0;
    redir_pc = '0; flush_pc = '0; imem_ready = 0; imem_resp = 0; imem_rdata = '0;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before any clock.
  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    m_reset();
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_imem_addr", imem_addr, 32'd0);
    chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    chk("rst_fetch_pc", fetch_pc, 32'd0);
    chk("rst_fetch_inst", fetch_inst, 32'd0);
    chk("rst_fetch_tid", 32'(fetch_tid), 32'd0);
    for (int t = 0; t < NT; t++)
      chk($sformatf("rst_thread_pc%0d", t), thread_pc[32*t +: 32], RPC + RSTRIDE * t);
    @(negedge clk);
    quiet();
    rst = 1'b1;
  endtask

  logic [31:0] got_pc [4];
  int          got_tid [4];
  int          got_cyc [4];
  int          n;
  logic [31:0] exp1_pc [4] = '{32'h6000_0000, 32'h6000_1000, 32'h6000_0004, 32'h6000_1004};
  int          exp1_tid [4] = '{0, 1, 0, 1};

  task automatic collect(input int want, input int budget);
    n = 0;
    for (int c = 0; c < budget && n < want; c++) begin
      imem_rdata = $urandom;
      cycle();
      if (fetch_valid) begin
        got_pc[n] = fetch_pc; got_tid[n] = int'(fetch_tid); got_cyc[n] = c; n++;
      end
    end
  endtask

  initial begin
    quiet();
    rst = 1'b1;
    m_reset();
    @(negedge clk);

    // Alternating round-robin fetch with zero-wait memory.
    do_reset();
    thread_en = 2'b11; imem_ready = 1; imem_resp = 1;
    collect(4, 30);
    chk("t1_count", n, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_pc%0d", i), got_pc[i], exp1_pc[i]);
      chk($sformatf("t1_tid%0d", i), got_tid[i], exp1_tid[i]);
      if (i > 0) chk($sformatf("t1_gap%0d", i), got_cyc[i] - got_cyc[i-1], 3);
    end

    // Thread 1 starved by a full IQ.
    do_reset();
    thread_en = 2'b11; iq_full = 2'b10; imem_ready = 1; imem_resp = 1;
    collect(3, 30);
    chk("t2_count", n, 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t2_pc%0d", i), got_pc[i], RPC + 4 * i);
      chk($sformatf("t2_tid%0d", i), got_tid[i], 0);
    end
    chk("t2_thread_pc1", thread_pc[63:32], 32'h6000_1000);

    // Redirect during WAIT discards the response.
    do_reset();
    thread_en = 2'b01; imem_ready = 1; imem_resp = 0;
    cycle();
    cycle();
    redir_valid = 2'b01; redir_pc[31:0] = 32'h6000_0200;
    cycle();
    redir_valid = '0; imem_resp = 1; imem_rdata = 32'hdead_beef;
    cycle();
    chk("t3_discard", 32'(fetch_valid), 32'd0);
    collect(1, 10);
    chk("t3_count", n, 1);
    chk("t3_pc", got_pc[0], 32'h6000_0200);

    // Flush beats redirect on the same thread.
    do_reset();
    flush_valid = 2'b01; flush_pc[31:0] = 32'h6000_0080;
    redir_valid = 2'b01; redir_pc[31:0] = 32'h6000_0300;
    cycle();
    quiet();
    chk("t4_flush_wins", thread_pc[31:0], 32'h6000_0080);

    // Request held while memory stalls, then dropped by a redirect on the owning thread.
    do_reset();
    thread_en = 2'b01; imem_ready = 0;
    cycle();
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk($sformatf("t5_req%0d", k), 32'(imem_req), 32'd1);
      chk($sformatf("t5_addr%0d", k), imem_addr, RPC);
    end
    redir_valid = 2'b01; redir_pc[31:0] = 32'h6000_0400;
    cycle();
    chk("t5_drop", 32'(imem_req), 32'd0);
    redir_valid = '0;
    cycle();
    chk("t5_regrant_req", 32'(imem_req), 32'd1);
    chk("t5_regrant_addr", imem_addr, 32'h6000_0400);

    // PC wrap, then reset while a request is in flight.
    do_reset();
    flush_valid = 2'b01; flush_pc[31:0] = 32'hFFFF_FFFC;
    cycle();
    flush_valid = '0; thread_en = 2'b01; imem_ready = 1; imem_resp = 1;
    collect(1, 10);
    chk("t6_count", n, 1);
    chk("t6_pc", got_pc[0], 32'hFFFF_FFFC);
    chk("t6_wrap", thread_pc[31:0], 32'h0000_0000);
    imem_resp = 0;
    cycle();
    cycle();
    do_reset();
    thread_en = 2'b01; imem_ready = 0;
    cycle();
    chk("t6_req_pending", 32'(imem_req), 32'd1);
    do_reset();
    imem_resp = 1;
    cycle();
    chk("t6_stale_resp_ignored", 32'(fetch_valid), 32'd0);

    // Randomized traffic, with one asynchronous reset in the middle.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (c == 300) do_reset();
      for (int t = 0; t < NT; t++) begin
        thread_en[t]   = ($urandom_range(0, 7) != 0);
        iq_full[t]     = ($urandom_range(0, 3) == 0);
        redir_valid[t] = ($urandom_range(0, 9) == 0);
        flush_valid[t] = ($urandom_range(0, 15) == 0);
        redir_pc[32*t +: 32] = $urandom & 32'hFFFF_FFFC;
        flush_pc[32*t +: 32] = $urandom & 32'hFFFF_FFFC;
      end
      imem_ready = ($urandom_range(0, 3) != 0);
      imem_resp  = ($urandom_range(0, 1) != 0);
      imem_rdata = $urandom;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
